// File: rtl/uart_frame_assembler_pkg.sv
// Shared definitions for the UART command frame path: FSM states, frame size
// default and the opcode characters the downstream decoders switch on.
package uart_frame_assembler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } fsm_state_t;

  localparam int DEFAULT_FRAME_BYTES = 18;

  localparam logic [7:0] OP_AT = 8'h40;  // "@"
  localparam logic [7:0] OP_A  = 8'h41;  // "A"
  localparam logic [7:0] OP_B  = 8'h42;  // "B"
  localparam logic [7:0] OP_C  = 8'h43;  // "C"
  localparam logic [7:0] OP_D  = 8'h44;  // "D"
  localparam logic [7:0] OP_G  = 8'h47;  // "G"
  localparam logic [7:0] OP_LA = 8'h61;  // "a"
  localparam logic [7:0] OP_LB = 8'h62;  // "b"

endpackage

// File: rtl/uart_frame_assembler_timeout.sv
// Loadable down-counter for the inter-byte timeout; expire is high during the
// last counting cycle, so it fires on the TIMEOUT_CYCLES-th idle cycle.
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 10_334_000,
  parameter int TO_BITS        = 24
) (
  input  logic clk,
  input  logic nreset,
  input  logic load,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_BITS-1:0] LOAD_VAL = TO_BITS'(TIMEOUT_CYCLES);

  logic [TO_BITS-1:0] cnt_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = en && (cnt_q == TO_BITS'(1));

endmodule

// File: rtl/uart_frame_assembler.sv
// Assembles UART RX bytes into fixed-length command frames, checks that the
// terminator repeats the opcode, and holds the frame until the decoder takes it.
module uart_frame_assembler
  import uart_frame_assembler_pkg::*;
#(
  parameter int FRAME_BYTES    = DEFAULT_FRAME_BYTES,
  parameter int TIMEOUT_CYCLES = 10_334_000,
  parameter int TO_BITS        = 24
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     clear,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [8*FRAME_BYTES-1:0] frame_data,
  output logic                     err_term,
  output logic                     err_timeout,
  output logic                     err_overrun,
  output logic [7:0]               err_count,
  output fsm_state_t               dbg_state
);

  // Handshake: frame_valid stays high with frame_data stable until a cycle in
  // which frame_ready is also high; that cycle transfers the frame.

  localparam int IDX_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  fsm_state_t               state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [8*FRAME_BYTES-1:0] frame_data_q;
  logic                     wr_en;
  logic                     term_d, timeout_d, overrun_d;
  logic                     term_q, timeout_q, overrun_q;
  logic [7:0]               err_count_q;
  logic                     to_load, to_clr, to_en, to_expire;

  frame_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_BITS       (TO_BITS)
  ) u_timeout (
    .clk   (clk),
    .nreset(nreset),
    .load  (to_load),
    .clr   (to_clr),
    .en    (to_en),
    .expire(to_expire)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_en     = 1'b0;
    term_d    = 1'b0;
    timeout_d = 1'b0;
    overrun_d = 1'b0;
    to_load   = 1'b0;
    to_clr    = 1'b0;
    to_en     = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      to_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid) begin
            wr_en = 1'b1;
            // A one-byte frame is its own terminator, so it always matches.
            if (LAST_IDX == '0) begin
              state_d = ST_HOLD;
            end else begin
              idx_d   = IDX_W'(1);
              state_d = ST_COLLECT;
              to_load = 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          to_en = !rx_valid;
          if (rx_valid) begin
            wr_en   = 1'b1;
            to_load = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              if (rx_data == frame_data_q[7:0]) begin
                state_d = ST_HOLD;
              end else begin
                term_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else if (to_expire) begin
            timeout_d = 1'b1;
            idx_d     = '0;
            state_d   = ST_IDLE;
          end
        end
        ST_HOLD: begin
          overrun_d = rx_valid;
          if (frame_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      frame_data_q <= '0;
      term_q       <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      term_q    <= term_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
      if (wr_en) begin
        frame_data_q[8*int'(idx_q) +: 8] <= rx_data;
      end
      if ((term_d || timeout_d || overrun_d) && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign frame_valid = (state_q == ST_HOLD);
  assign frame_data  = frame_data_q;
  assign err_term    = term_q;
  assign err_timeout = timeout_q;
  assign err_overrun = overrun_q;
  assign err_count   = err_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed bench for uart_frame_assembler: 18-byte frames, 100-cycle timeout.
module tb_uart_frame_assembler;
  import uart_frame_assembler_pkg::*;

  localparam int FB = 18;
  localparam int TO = 100;

  logic          clk;
  logic          nreset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          clear;
  logic          frame_valid;
  logic          frame_ready;
  logic [8*FB-1:0] frame_data;
  logic          err_term;
  logic          err_timeout;
  logic          err_overrun;
  logic [7:0]    err_count;
  fsm_state_t    dbg_state;

  int tests;
  int fails;

  uart_frame_assembler #(
    .FRAME_BYTES   (FB),
    .TIMEOUT_CYCLES(TO),
    .TO_BITS       (24)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .clear      (clear),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_data (frame_data),
    .err_term   (err_term),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun),
    .err_count  (err_count),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8*FB-1:0] obs, input logic [8*FB-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // b0, b1, 15 x fill, last; stops before the last byte so callers can check it
  task automatic send_17(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] fill);
    send_byte(b0);
    send_byte(b1);
    for (int i = 0; i < 15; i++) send_byte(fill);
  endtask

  logic [8*FB-1:0] exp_fd;
  int              seen;

  initial begin
    tests       = 0;
    fails       = 0;
    nreset      = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    clear       = 1'b0;
    frame_ready = 1'b0;
    #12;
    chk("reset_frame_valid", frame_valid, 0);
    chk("reset_err_count", err_count, 0);
    chk("reset_frame_data", frame_data, 0);
    chk("reset_state", dbg_state, ST_IDLE);
    chk("reset_errs", {err_term, err_timeout, err_overrun}, 0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    tick();

    // basic frame A C x*15 A with consumer ready
    frame_ready = 1'b1;
    send_17(OP_A, OP_C, 8'h78);
    chk("basic_not_early", frame_valid, 0);
    send_byte(OP_A);
    chk("basic_valid", frame_valid, 1);
    chk("basic_b0", frame_data[7:0], 8'h41);
    chk("basic_b1", frame_data[15:8], 8'h43);
    chk("basic_b2", frame_data[23:16], 8'h78);
    chk("basic_b17", frame_data[143:136], 8'h41);
    tick();
    chk("basic_one_cycle", frame_valid, 0);
    chk("basic_idle", dbg_state, ST_IDLE);

    // terminator mismatch D ... E
    send_17(OP_D, 8'h01, 8'h02);
    send_byte(8'h45);
    chk("term_pulse", err_term, 1);
    chk("term_no_valid", frame_valid, 0);
    chk("term_count", err_count, 1);
    tick();
    chk("term_one_cycle", err_term, 0);
    send_17(OP_B, 8'h10, 8'h20);
    send_byte(OP_B);
    chk("after_term_valid", frame_valid, 1);
    chk("after_term_b1", frame_data[15:8], 8'h10);
    tick();

    // timeout after 5 bytes
    for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i));
    seen = 0;
    for (int i = 1; i < TO; i++) begin
      tick();
      if (err_timeout) seen++;
    end
    chk("timeout_not_early", seen, 0);
    chk("timeout_still_collect", dbg_state, ST_COLLECT);
    tick();
    chk("timeout_pulse", err_timeout, 1);
    chk("timeout_count", err_count, 2);
    chk("timeout_idle", dbg_state, ST_IDLE);
    send_17(OP_G, 8'h55, 8'h66);
    send_byte(OP_G);
    chk("after_timeout_valid", frame_valid, 1);
    chk("after_timeout_b0", frame_data[7:0], OP_G);
    chk("after_timeout_b2", frame_data[23:16], 8'h66);
    tick();

    // overrun while held
    frame_ready = 1'b0;
    exp_fd = '0;
    exp_fd[7:0] = OP_LA;
    exp_fd[15:8] = 8'h99;
    for (int k = 2; k < 17; k++) exp_fd[8*k +: 8] = 8'h11;
    exp_fd[143:136] = OP_LA;
    send_17(OP_LA, 8'h99, 8'h11);
    send_byte(OP_LA);
    chk("hold_valid", frame_valid, 1);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hE0 + 8'(i));
      if (err_overrun) seen++;
    end
    chk("overrun_pulses", seen, 3);
    chk("overrun_count", err_count, 5);
    chk("overrun_data", frame_data, exp_fd);
    chk("overrun_still_valid", frame_valid, 1);
    tick();
    chk("overrun_pulse_ends", err_overrun, 0);
    frame_ready = 1'b1;
    send_byte(8'hEE);
    chk("accept_overrun", err_overrun, 1);
    chk("accept_idle", dbg_state, ST_IDLE);
    chk("accept_valid_low", frame_valid, 0);
    chk("accept_count", err_count, 6);

    // clear coincident with byte 9
    for (int i = 0; i < 8; i++) send_byte(OP_C);
    clear = 1'b1;
    send_byte(OP_C);
    clear = 1'b0;
    chk("clear_idle", dbg_state, ST_IDLE);
    chk("clear_no_err", {err_term, err_timeout, err_overrun}, 0);
    chk("clear_count", err_count, 6);
    send_17(OP_LB, 8'h07, 8'h08);
    chk("clear_restart_not_early", frame_valid, 0);
    send_byte(OP_LB);
    chk("clear_restart_valid", frame_valid, 1);
    chk("clear_restart_b0", frame_data[7:0], OP_LB);
    tick();

    // asynchronous reset while holding a frame
    frame_ready = 1'b0;
    send_17(OP_AT, 8'h01, 8'h02);
    send_byte(OP_AT);
    chk("pre_reset_hold", frame_valid, 1);
    nreset = 1'b0;
    #1;
    chk("rst_hold_valid", frame_valid, 0);
    chk("rst_hold_count", err_count, 0);
    chk("rst_hold_data", frame_data, 0);
    chk("rst_hold_state", dbg_state, ST_IDLE);
    tick();
    nreset = 1'b1;
    tick();
    chk("rst_release_errs", {err_term, err_timeout, err_overrun}, 0);
    frame_ready = 1'b1;

    // saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      send_17(OP_D, 8'h00, 8'h00);
      send_byte(8'h45);
      if (i == 253) chk("sat_254", err_count, 254);
      if (i == 254) chk("sat_255", err_count, 255);
    end
    chk("sat_term_pulse", err_term, 1);
    chk("sat_hold", err_count, 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
